// File: rtl/prefix_adder_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with valid/ready at both ends; prefix levels are spread over STAGES registers.
// Define PREFIX_ADD_FLAGS_EN to add the registered ovf and zero flag outputs.
module prefix_adder_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z,
    output logic             cout
`ifdef PREFIX_ADD_FLAGS_EN
   ,output logic             ovf,
    output logic             zero
`endif
);

    localparam int LEVELS = $clog2(WIDTH);
    localparam int BASE   = LEVELS / STAGES;
    localparam int EXTRA  = LEVELS % STAGES;

    // First prefix level handled by a stage; earlier stages absorb the remainder.
    function automatic int level_start(input int stage);
        return stage * BASE + ((stage < EXTRA) ? stage : EXTRA);
    endfunction

    logic             en;
    logic [WIDTH-1:0] y_eff;
    logic             c0_in;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;
    assign y_eff    = sub ? ~y : y;
    assign c0_in    = sub ? 1'b1 : cin;

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        localparam int LO = level_start(gi);
        localparam int HI = level_start(gi + 1);

        logic [WIDTH-1:0] g_in, p_in, e_in;
        logic [WIDTH-1:0] g_out, p_out;
        logic             c0, v_in;

        if (gi == 0) begin : g_first
            assign g_in = x & y_eff;
            assign p_in = x | y_eff;
            assign e_in = x ^ y_eff;
            assign c0   = c0_in;
            assign v_in = in_valid && en;
        end else begin : g_next
            assign g_in = g_stage[gi-1].g_mid.g_reg;
            assign p_in = g_stage[gi-1].g_mid.p_reg;
            assign e_in = g_stage[gi-1].g_mid.e_reg;
            assign c0   = g_stage[gi-1].g_mid.c0_reg;
            assign v_in = g_stage[gi-1].g_mid.v_reg;
        end

        // Descending i so each update still reads the lower, not-yet-updated span.
        always_comb begin
            g_out = g_in;
            p_out = p_in;
            for (int l = LO; l < HI; l++) begin
                for (int i = WIDTH - 1; i >= (1 << l); i--) begin
                    g_out[i] = g_out[i] | (p_out[i] & g_out[i - (1 << l)]);
                    p_out[i] = p_out[i] & p_out[i - (1 << l)];
                end
            end
        end

        if (gi < STAGES - 1) begin : g_mid
            logic [WIDTH-1:0] g_reg, p_reg, e_reg;
            logic             c0_reg, v_reg;

            always_ff @(posedge clk or negedge rst_b) begin
                if (!rst_b) begin
                    g_reg  <= '0;
                    p_reg  <= '0;
                    e_reg  <= '0;
                    c0_reg <= 1'b0;
                    v_reg  <= 1'b0;
                end else if (en) begin
                    g_reg  <= g_out;
                    p_reg  <= p_out;
                    e_reg  <= e_in;
                    c0_reg <= c0;
                    v_reg  <= v_in;
                end
            end
        end else begin : g_last
            logic [WIDTH-1:0] carry;
            logic [WIDTH-1:0] z_next;
            logic             cout_next;

            // Group terms cover [i:0]; fold in the carry-in as the bit -1 generate.
            always_comb begin
                carry[0] = c0;
                for (int i = 1; i < WIDTH; i++) begin
                    carry[i] = g_out[i-1] | (p_out[i-1] & c0);
                end
                z_next    = e_in ^ carry;
                cout_next = g_out[WIDTH-1] | (p_out[WIDTH-1] & c0);
            end

            always_ff @(posedge clk or negedge rst_b) begin
                if (!rst_b) begin
                    out_valid <= 1'b0;
                    z         <= '0;
                    cout      <= 1'b0;
`ifdef PREFIX_ADD_FLAGS_EN
                    ovf       <= 1'b0;
                    zero      <= 1'b0;
`endif
                end else if (en) begin
                    out_valid <= v_in;
                    z         <= z_next;
                    cout      <= cout_next;
`ifdef PREFIX_ADD_FLAGS_EN
                    // Signed overflow is exactly carry-into-MSB differing from carry-out.
                    ovf       <= carry[WIDTH-1] ^ cout_next;
                    zero      <= ~|z_next;
`endif
                end
            end
        end
    end

endmodule
